mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

Multi-cycle controller that executes one decoded load or store at a time against a single-ported, word-wide, req/ack data memory. Sits between the execute stage (fed by the decoder's `load`, `store`, `loadUnsigned`, `memLength` and the ALU-computed address) and the data memory. It stalls the pipeline while the access is in flight, performs sub-word lane selection and sign/zero extension, and flags misaligned or malformed accesses.

## Interface
- `ADDR_WIDTH`, 32: byte-address width; memory word address is `ADDR_WIDTH-2` bits.
- `DATA_WIDTH`, 32 (`` `DATA_WIDTH ``): data width; must be 32.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: execute stage holds a memory instruction; sampled only in IDLE.
- `load`, `store` in 1 each: decoder access flags.
- `loadUnsigned` in 1: zero-extend instead of sign-extend.
- `memLength` in 2: 0 = byte, 1 = half, 3 = word, 2 = illegal.
- `address` in ADDR_WIDTH: byte address.
- `storeData` in DATA_WIDTH: rs2 value; low bits used for sub-word.
- `busy` out 1: pipeline stall.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: pulses with `done` on a rejected access.
- `loadData` out DATA_WIDTH: extended load result; valid with `done`, held until next `done`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out ADDR_WIDTH-2, `mem_wdata` out 32, `mem_be` out 4.
- `mem_ack` in 1, `mem_rdata` in 32: rdata valid in the ack cycle.

## Operation
- States: IDLE, ACCESS, RMW_RD, RMW_WR, DONE.
- IDLE, with `start`:
  - Reject if `load == store`, `memLength == 2`, half with `address[0] = 1`, or word with `address[1:0] != 0`. Go to DONE with error, no memory traffic.
  - Otherwise latch address, data, length and unsigned flag, then go to ACCESS.
  - Without `BYTE_ENABLE_EN`, a sub-word store goes to RMW_RD instead.
- ACCESS: `mem_req` = 1. `mem_we` is 1 for a store, 0 for a load. Wait for `mem_ack`, then go to DONE.
- RMW_RD: read the word. On ack, merge the store lane into the read data, then go to RMW_WR.
- RMW_WR: write the merged word. On ack, go to DONE.
- DONE: `done` = 1 for one cycle, then IDLE. `start` is ignored in this state.
- Load extraction:
  - Byte lane = `address[1:0]`; half lane = `address[1]`.
  - Extend bit 7 or bit 15, or zero when unsigned.
  - Word loads pass through.
- Handshake:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` are registered and stable while `mem_req` is high.
  - Each ack consumes exactly one transaction.
  - `mem_ack` is ignored while `mem_req` is low.
  - A new transaction (RMW write) may start the cycle after an ack.
- `busy` = (IDLE && `start`) || state ∈ {ACCESS, RMW_RD, RMW_WR}. `busy` is 0 in DONE so the pipeline advances that cycle.

## Timing
- All outputs reset to 0 (`loadData` included). The state resets to IDLE.
- `start` at edge N: `mem_req` high from N+1.
  - Ack sampled at edge M gives `done` in cycle M+1, with `mem_req` low.
  - Zero-wait memory: load or store takes 3 cycles from start to done inclusive.
  - RMW adds one transaction.
- Rejected access: `done` and `error` appear the cycle after `start`.
- Reset mid-transaction: `mem_req` drops immediately (asynchronous). No `done` is issued. The pending transaction is abandoned, and the memory must tolerate a dropped req.
- Back-to-back: the next `start` is accepted in the IDLE cycle following DONE.

## Configuration
- `BYTE_ENABLE_EN` defined:
  - Sub-word stores are a single write.
  - `mem_wdata` = byte replicated ×4 or half replicated ×2.
  - `mem_be` = `4'b0001 << address[1:0]` (byte), or `4'b0011 << {address[1],1'b0}` (half), or `4'b1111` (word).
- `BYTE_ENABLE_EN` undefined:
  - `mem_be` is tied to `4'b1111`.
  - Sub-word stores use RMW_RD → RMW_WR read-modify-write.

## Test plan
- LB, addr 0x103, rdata 0x80AABBCC, ack after 2 cycles → `loadData` 0xFFFFFF80, `mem_addr` 0x40, `done` 1 cycle, `busy` high 3 cycles.
- LHU, addr 0x102, rdata 0x8001_1234 → `loadData` 0x00008001. LW, addr 0x0, rdata 0xDEADBEEF → `loadData` 0xDEADBEEF.
- SB, addr 0x101, storeData 0x55:
  - With `BYTE_ENABLE_EN`: `mem_be` 0b0010, `mem_wdata` 0x55555555.
  - Without it: read 0x11223344 then write 0x11225544.
- LW, addr 0x102 → `error` and `done` the cycle after `start`, `mem_req` never asserted. `load = store = 1` → same response.
- Assert `reset` while `mem_req` is high waiting for ack → `mem_req`, `busy` and `done` go to 0 immediately. The next LW completes normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer between the execute stage and a req/ack word memory.
// Define BYTE_ENABLE_EN for byte-enabled sub-word stores; otherwise they use read-modify-write.
module mem_access_sequencer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  load,
   input  logic                  store,
   input  logic                  loadUnsigned,
   input  logic [1:0]            memLength,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] storeData,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] loadData,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_rdata,
   output logic [2:0]            dbg_state_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCESS = 3'd1,
      RMW_RD = 3'd2,
      RMW_WR = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             sdata_q, sdata_d;
   logic [1:0]              len_q, len_d;
   logic                    uns_q, uns_d;
   logic                    err_q, err_d;
   logic                    req_q, req_d;
   logic                    we_q, we_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   ldata_q, ldata_d;
`ifdef BYTE_ENABLE_EN
   logic [3:0]              be_q, be_d;
`endif

   logic        reject;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] ext_v;
   logic [31:0] merged_v;

   assign reject = (load == store) || (memLength == 2'd2) ||
                   (memLength == 2'd1 && address[0]) ||
                   (memLength == 2'd3 && address[1:0] != 2'b00);

   // Lane extraction for loads and lane merge for read-modify-write stores.
   always_comb begin
      byte_v   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_v   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      merged_v = mem_rdata;
      unique case (len_q)
         2'd0: begin
            ext_v = {{24{~uns_q & byte_v[7]}}, byte_v};
            merged_v[{addr_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
         end
         2'd1: begin
            ext_v = {{16{~uns_q & half_v[15]}}, half_v};
            merged_v[{addr_q[1], 4'b0000} +: 16] = sdata_q[15:0];
         end
         default: ext_v = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         sdata_q <= '0;
         len_q   <= '0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         ldata_q <= '0;
`ifdef BYTE_ENABLE_EN
         be_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
         len_q   <= len_d;
         uns_q   <= uns_d;
         err_q   <= err_d;
         req_q   <= req_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         ldata_q <= ldata_d;
`ifdef BYTE_ENABLE_EN
         be_q    <= be_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sdata_d = sdata_q;
      len_d   = len_q;
      uns_d   = uns_q;
      err_d   = err_q;
      req_d   = req_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      ldata_d = ldata_q;
`ifdef BYTE_ENABLE_EN
      be_d    = be_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start && reject) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else if (start) begin
               err_d   = 1'b0;
               addr_d  = address;
               sdata_d = storeData;
               len_d   = memLength;
               uns_d   = loadUnsigned;
               req_d   = 1'b1;
               we_d    = store;
               wdata_d = storeData;
               state_d = ACCESS;
`ifdef BYTE_ENABLE_EN
               be_d    = 4'b1111;
               if (store && memLength == 2'd0) begin
                  wdata_d = {4{storeData[7:0]}};
                  be_d    = 4'b0001 << address[1:0];
               end else if (store && memLength == 2'd1) begin
                  wdata_d = {2{storeData[15:0]}};
                  be_d    = 4'b0011 << {address[1], 1'b0};
               end
`else
               // Without byte enables a sub-word store must read the word first.
               if (store && memLength != 2'd3) begin
                  we_d    = 1'b0;
                  state_d = RMW_RD;
               end
`endif
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = DONE;
               if (!we_q) ldata_d = ext_v;
            end
         end
         RMW_RD: begin
            if (mem_ack) begin
               we_d    = 1'b1;
               wdata_d = merged_v;
               state_d = RMW_WR;
            end
         end
         RMW_WR: begin
            if (mem_ack) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // busy drops in DONE so the pipeline advances while done pulses.
   always_comb begin
      busy  = (state_q == IDLE && start) || (state_q == ACCESS) ||
              (state_q == RMW_RD) || (state_q == RMW_WR);
      done  = (state_q == DONE);
      error = (state_q == DONE) && err_q;
   end

   assign loadData    = ldata_q;
   assign mem_req     = req_q;
   assign mem_we      = we_q;
   assign mem_addr    = addr_q[ADDR_WIDTH-1:2];
   assign mem_wdata   = wdata_q;
   assign dbg_state_o = state_q;
`ifdef BYTE_ENABLE_EN
   assign mem_be      = be_q;
`else
   assign mem_be      = 4'b1111;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a small req/ack word-memory responder.
// Build with BYTE_ENABLE_EN defined to cover the byte-enabled store variant.
module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0, load = 1'b0, store = 1'b0, loadUnsigned = 1'b0;
   logic [1:0]  memLength = 2'd0;
   logic [31:0] address = '0, storeData = '0;
   logic        busy, done, error;
   logic [31:0] loadData;
   logic        mem_req, mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [2:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [0:255];
   int          ack_delay = 0;
   int          wait_cnt  = 0;
   int          txn_cnt   = 0;
   logic [29:0] last_addr = '0;
   logic [31:0] last_wdata = '0;
   logic [3:0]  last_be = '0;

   int          busy_cyc, done_at, done_len;
   logic        err_seen, req_seen;

   mem_access_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .load(load), .store(store),
      .loadUnsigned(loadUnsigned), .memLength(memLength), .address(address),
      .storeData(storeData), .busy(busy), .done(done), .error(error),
      .loadData(loadData), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   // Memory responder: acks after ack_delay wait cycles, applies byte-enabled writes.
   always begin
      @(posedge clk);
      #1;
      if (reset) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end else begin
         if (mem_ack) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
         end
         if (mem_req && wait_cnt == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr[7:0]];
            last_addr = mem_addr;
            txn_cnt++;
            if (mem_we) begin
               last_wdata = mem_wdata;
               last_be    = mem_be;
               for (int b = 0; b < 4; b++)
                  if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
         end else if (mem_req) begin
            wait_cnt++;
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; cycle 1 is the start cycle.
   task automatic do_op(input logic ld, input logic st, input logic uns, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] sdata);
      load = ld; store = st; loadUnsigned = uns; memLength = len;
      address = addr; storeData = sdata; start = 1'b1;
      busy_cyc = 0; done_at = 0; done_len = 0; err_seen = 1'b0; req_seen = 1'b0;
      txn_cnt = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy) busy_cyc++;
         if (mem_req) req_seen = 1'b1;
         if (done) begin
            done_len++;
            if (done_at == 0) begin
               done_at  = i;
               err_seen = error;
            end
         end
         @(posedge clk);
         #1;
         start = 1'b0; load = 1'b0; store = 1'b0;
         if (done_at != 0 && i > done_at) break;
      end
      if (done_at == 0) check("timeout_no_done", 32'(done_at), 32'(1));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      @(negedge clk);
      check("rst_ctrl", {26'd0, busy, done, error, mem_req, mem_we, dbg_state == 3'd0},
            32'h1);
      check("rst_loaddata", loadData, 32'h0);
      check("rst_mem", {mem_wdata[31:2] | mem_addr, 2'b00}, 32'h0);
`ifdef BYTE_ENABLE_EN
      check("rst_be", {28'd0, mem_be}, 32'h0);
`else
      check("rst_be", {28'd0, mem_be}, 32'hF);
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // LB 0x103 with one wait cycle
      mem[8'h40] = 32'h80AABBCC; ack_delay = 1;
      do_op(1, 0, 0, 2'd0, 32'h103, 32'h0);
      check("lb_data", loadData, 32'hFFFFFF80);
      check("lb_addr", {2'b00, last_addr}, 32'h40);
      check("lb_done_at", 32'(done_at), 32'd4);
      check("lb_done_len", 32'(done_len), 32'd1);
      check("lb_busy", 32'(busy_cyc), 32'd3);
      check("lb_err", {31'd0, err_seen}, 32'd0);
      ack_delay = 0;

      mem[8'h40] = 32'h80011234;
      do_op(1, 0, 1, 2'd1, 32'h102, 32'h0);
      check("lhu_data", loadData, 32'h00008001);
      check("lhu_done_at", 32'(done_at), 32'd3);
      do_op(1, 0, 0, 2'd1, 32'h102, 32'h0);
      check("lh_data", loadData, 32'hFFFF8001);

      mem[8'h40] = 32'h11223344;
      do_op(1, 0, 1, 2'd0, 32'h101, 32'h0);
      check("lbu_data", loadData, 32'h00000033);

      mem[8'h00] = 32'hDEADBEEF;
      do_op(1, 0, 0, 2'd3, 32'h0, 32'h0);
      check("lw_data", loadData, 32'hDEADBEEF);
      check("lw_busy", 32'(busy_cyc), 32'd2);

      // SB 0x101
      mem[8'h40] = 32'h11223344;
      do_op(0, 1, 0, 2'd0, 32'h101, 32'hAAAAAA55);
      check("sb_mem", mem[8'h40], 32'h11225544);
      check("sb_loaddata_held", loadData, 32'hDEADBEEF);
`ifdef BYTE_ENABLE_EN
      check("sb_be", {28'd0, last_be}, 32'h2);
      check("sb_wdata", last_wdata, 32'h55555555);
      check("sb_txns", 32'(txn_cnt), 32'd1);
      check("sb_done_at", 32'(done_at), 32'd3);
`else
      check("sb_be", {28'd0, last_be}, 32'hF);
      check("sb_wdata", last_wdata, 32'h11225544);
      check("sb_txns", 32'(txn_cnt), 32'd2);
      check("sb_done_at", 32'(done_at), 32'd4);
`endif

      // SH 0x106
      mem[8'h41] = 32'hCAFEF00D;
      do_op(0, 1, 0, 2'd1, 32'h106, 32'h1234BEEF);
      check("sh_mem", mem[8'h41], 32'hBEEFF00D);
`ifdef BYTE_ENABLE_EN
      check("sh_be", {28'd0, last_be}, 32'hC);
      check("sh_wdata", last_wdata, 32'hBEEFBEEF);
`else
      check("sh_txns", 32'(txn_cnt), 32'd2);
`endif

      mem[8'h42] = 32'h0;
      do_op(0, 1, 0, 2'd3, 32'h108, 32'hA5A55A5A);
      check("sw_mem", mem[8'h42], 32'hA5A55A5A);
      check("sw_txns", 32'(txn_cnt), 32'd1);
      check("sw_be", {28'd0, last_be}, 32'hF);

      // Rejected accesses
      do_op(1, 0, 0, 2'd3, 32'h102, 32'h0);
      check("mis_lw_err", {31'd0, err_seen}, 32'd1);
      check("mis_lw_done_at", 32'(done_at), 32'd2);
      check("mis_lw_noreq", {31'd0, req_seen}, 32'd0);
      check("mis_lw_held", loadData, 32'hDEADBEEF);
      do_op(1, 1, 0, 2'd3, 32'h0, 32'h0);
      check("ldst_err", {31'd0, err_seen}, 32'd1);
      check("ldst_noreq", {31'd0, req_seen}, 32'd0);
      do_op(1, 0, 0, 2'd2, 32'h0, 32'h0);
      check("len2_err", {31'd0, err_seen}, 32'd1);
      do_op(0, 1, 0, 2'd1, 32'h101, 32'h0);
      check("mis_sh_err", {31'd0, err_seen}, 32'd1);
      check("mis_sh_done_len", 32'(done_len), 32'd1);

      // Reset while waiting for ack
      ack_delay = 1000;
      load = 1'b1; memLength = 2'd3; address = 32'h10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; load = 1'b0;
      @(negedge clk);
      check("rstmid_req_before", {31'd0, mem_req}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check("rstmid_req", {31'd0, mem_req}, 32'd0);
      check("rstmid_busy_done", {30'd0, busy, done}, 32'd0);
      @(posedge clk); #1;
      ack_delay = 0;
      reset = 1'b0;
      mem[8'h04] = 32'h12345678;
      do_op(1, 0, 0, 2'd3, 32'h10, 32'h0);
      check("post_rst_lw", loadData, 32'h12345678);
      check("post_rst_done_at", 32'(done_at), 32'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
